seq_mul8_ctrl: RTL and testbench
================================

SEQ_MUL8_CTRL -- requirements
Module: seq_mul8_ctrl

Interface
REQ-001 SHALL have parameter NSTEP, default 4, meaning the number of partial-product steps; fixed at 4 and not to be overridden.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a new multiply; sampled only in IDLE.
REQ-005 SHALL have port a  input  8  unsigned multiplicand; captured when start is accepted.
REQ-006 SHALL have port b  input  8  unsigned multiplier; captured when start is accepted.
REQ-007 SHALL have port busy  output  1  high in CALC and DONE.
REQ-008 SHALL have port done  output  1  one-cycle pulse; p is valid in that cycle.
REQ-009 SHALL have port p  output  16  unsigned product a*b.

Function
REQ-010 SHALL use an FSM with three states: IDLE, CALC and DONE.
REQ-011 SHALL apply these transitions:
- IDLE goes to CALC on start=1.
- CALC holds for exactly 4 cycles (step 0..3), then goes to DONE.
- DONE goes to IDLE after 1 cycle.
REQ-012 SHALL latch a and b on the clk edge that accepts start; later changes on a and b SHALL NOT affect the running operation.
REQ-013 SHALL time-share one 4x4 unsigned multiplier core across the four CALC steps:
- step0: a[3:0]*b[3:0], shifted left 0.
- step1: a[3:0]*b[7:4], shifted left 4.
- step2: a[7:4]*b[3:0], shifted left 4.
- step3: a[7:4]*b[7:4], shifted left 8.
REQ-014 SHALL clear the 16-bit accumulator on start acceptance and add one shifted partial product per CALC cycle; no overflow is possible (max 0xFE01).
REQ-015 SHALL have a latency of 5 cycles: start sampled at edge k means busy=1 from edge k until edge k+5, and done=1 between edges k+4 and k+5.
REQ-016 SHALL update p only on entry to DONE and hold it until the next DONE.
REQ-017 SHALL ignore start while busy=1, including the DONE cycle; there is no queuing.
REQ-018 SHALL accept start in the first IDLE cycle after DONE, giving a back-to-back throughput of one result per 6 cycles.
REQ-019 SHALL drive done only in DONE, never for more than one cycle.

Reset
REQ-020 SHALL, when rst_n=0 at any time including mid-CALC, immediately force state=IDLE, step=0, accumulator=0, p=0x0000, busy=0 and done=0, abandoning the operation with no done.
REQ-021 SHALL accept start on the first rising clk edge after rst_n deasserts.

Configuration
REQ-022 SHALL, with SEQ_MUL8_OPCNT_EN defined, add output port op_cnt (output, 8 bits):
- reset value 0.
- increments by 1 each DONE cycle.
- wraps from 255 to 0.
REQ-023 SHALL, without SEQ_MUL8_OPCNT_EN, omit the op_cnt port and its counter entirely; all other behaviour SHALL be identical.

Structure
REQ-024 SHALL take the FSM state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2), the NSTEP constant and the per-step shift table from shared package mul_pkg.
REQ-025 SHALL instantiate exactly one sub-module, mul4x4_core: combinational, 4-bit a and b in, 8-bit product out, carry-save adder tree with a final ripple row.
REQ-026 SHALL keep all sequencing in seq_mul8_ctrl; mul4x4_core SHALL contain no state.

Verification
REQ-027 SHALL cover a=0x00, b=0x00 with a start pulse -> done in the 5th cycle, p=0x0000.
REQ-028 SHALL cover a=0xFF, b=0xFF -> p=0xFE01 at done, with busy high for exactly 5 cycles.
REQ-029 SHALL cover a=0x0F, b=0x10, then start again in the first IDLE cycle after DONE with a=0xA5, b=0x3C -> p=0x00F0, then p=0x26AC, 6 cycles apart.
REQ-030 SHALL cover start re-pulsed during CALC with a=0x01, b=0x01 -> ignored; the first result is unchanged and only one done occurs.
REQ-031 SHALL cover rst_n pulsed low during CALC step 2 -> busy=0, p=0x0000, no done; a new start after release completes normally.
REQ-032 SHALL cover, with SEQ_MUL8_OPCNT_EN, 257 back-to-back operations -> op_cnt reads 1 after the last done (wrapped at 256).

Source files
------------

// File: rtl/mul_pkg.sv
// ============================================================================
// Module : mul_pkg
// Brief  : Shared FSM encoding, step count and per-step shift table for the
//          sequential 8x8 multiplier.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NSTEP  = 4;
  localparam int STEP_W = 2;

  // Left shift applied to the 4x4 partial product of each CALC step.
  function automatic logic [3:0] step_shift(input logic [STEP_W-1:0] step);
    logic [3:0] sh;
    sh = 4'd0;
    case (step)
      2'd1:    sh = 4'd4;
      2'd2:    sh = 4'd4;
      2'd3:    sh = 4'd8;
      default: sh = 4'd0;
    endcase
    return sh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul4x4_core.sv
// ============================================================================
// Module : mul4x4_core
// Brief  : Combinational 4x4 unsigned multiplier; two carry-save levels
//          reduce four partial-product rows, a ripple row resolves the sum.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul4x4_core (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);

  logic [7:0] w_row [4];
  logic [7:0] w_s1, w_c1, w_s2, w_c2;
  logic [7:0] w_carry;

  for (genvar i = 0; i < 4; i++) begin : g_rows
    assign w_row[i] = {4'd0, (i_a & {4{i_b[i]}})} << i;
  end

  // Product never exceeds 8 bits, so carries shifted out of bit 7 are zero.
  assign w_s1 = w_row[0] ^ w_row[1] ^ w_row[2];
  assign w_c1 = ((w_row[0] & w_row[1]) | (w_row[0] & w_row[2]) |
                 (w_row[1] & w_row[2])) << 1;
  assign w_s2 = w_s1 ^ w_c1 ^ w_row[3];
  assign w_c2 = ((w_s1 & w_c1) | (w_s1 & w_row[3]) | (w_c1 & w_row[3])) << 1;

  assign w_carry[0] = 1'b0;
  for (genvar i = 0; i < 8; i++) begin : g_ripple
    assign o_p[i] = w_s2[i] ^ w_c2[i] ^ w_carry[i];
    if (i < 7) begin : g_cy
      assign w_carry[i+1] = (w_s2[i] & w_c2[i]) | (w_s2[i] & w_carry[i]) |
                            (w_c2[i] & w_carry[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_mul8_ctrl.sv
// ============================================================================
// Module : seq_mul8_ctrl
// Brief  : Sequential 8x8 unsigned multiplier, one shared 4x4 core over four
//          CALC steps. Optional op_cnt output with SEQ_MUL8_OPCNT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mul8_ctrl
  import mul_pkg::*;
#(
  parameter int NSTEP = mul_pkg::NSTEP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] p
`ifdef SEQ_MUL8_OPCNT_EN
  ,
  output logic [7:0]  op_cnt
`endif
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

  state_t             r_state;
  logic [STEP_W-1:0]  r_step;
  logic [7:0]         r_a, r_b;
  logic [15:0]        r_acc;

  logic [3:0]         w_a_nib, w_b_nib;
  logic [7:0]         w_prod;
  logic [15:0]        w_pp, w_sum;

  // Step bit 1 picks the multiplicand nibble, bit 0 the multiplier nibble.
  assign w_a_nib = r_step[1] ? r_a[7:4] : r_a[3:0];
  assign w_b_nib = r_step[0] ? r_b[7:4] : r_b[3:0];

  mul4x4_core u_core (
    .i_a (w_a_nib),
    .i_b (w_b_nib),
    .o_p (w_prod)
  );

  assign w_pp  = {8'd0, w_prod} << step_shift(r_step);
  assign w_sum = r_acc + w_pp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
      r_a     <= 8'd0;
      r_b     <= 8'd0;
      r_acc   <= 16'd0;
      p       <= 16'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= 16'd0;
            r_step  <= '0;
            busy    <= 1'b1;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_acc <= w_sum;
          if (r_step == LAST_STEP) begin
            p       <= w_sum;
            done    <= 1'b1;
            r_step  <= '0;
            r_state <= ST_DONE;
          end else begin
            r_step <= r_step + 1'b1;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SEQ_MUL8_OPCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt <= 8'd0;
    end else if (r_state == ST_CALC && r_step == LAST_STEP) begin
      op_cnt <= op_cnt + 8'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_mul8_ctrl.sv
// ============================================================================
// Module : tb_seq_mul8_ctrl
// Brief  : Directed self-checking bench for seq_mul8_ctrl with a result
//          scoreboard; exercises op_cnt when SEQ_MUL8_OPCNT_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_mul8_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] p;
`ifdef SEQ_MUL8_OPCNT_EN
  logic [7:0]  op_cnt;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_done  = 0;
  int          cyc     = 0;
  logic        prev_done = 1'b0;
  logic [15:0] exp_q [$];
  int          done_t [$];
  logic [15:0] last_p = 16'd0;

  seq_mul8_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .p      (p)
`ifdef SEQ_MUL8_OPCNT_EN
    ,
    .op_cnt (op_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pops one expected product.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      n_done++;
      done_t.push_back(cyc);
      chk("done_width", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("p_at_done", {16'd0, p}, {16'd0, e});
      end
    end
    prev_done = done;
  end

  // Starts at a negedge; returns at the negedge after the DONE->IDLE edge.
  task automatic op(input logic [7:0] ai, input logic [7:0] bi, input bit timing);
    logic [15:0] e;
    e = 16'(ai) * 16'(bi);
    a = ai; b = bi; start = 1'b1;
    exp_q.push_back(e);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j == 0) start = 1'b0;
      if (timing) begin
        chk("busy_window", {31'd0, busy}, {31'd0, (j < 5)});
        chk("done_cycle",  {31'd0, done}, {31'd0, (j == 4)});
        if (j == 1) chk("p_hold_calc", {16'd0, p}, {16'd0, last_p});
      end
    end
    last_p = e;
  endtask

  initial begin
    int nd;
    int t0;
    rst_n = 1'b0; start = 1'b0; a = 8'd0; b = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_p",    {16'd0, p},    32'd0);
`ifdef SEQ_MUL8_OPCNT_EN
    chk("rst_opcnt", {24'd0, op_cnt}, 32'd0);
`endif
    rst_n = 1'b1;

    // Start on the first edge after reset release.
    op(8'h00, 8'h00, 1'b1);
    op(8'hFF, 8'hFF, 1'b1);
    chk("p_hold_idle", {16'd0, p}, 32'h0000FE01);

    t0 = done_t.size();
    op(8'h0F, 8'h10, 1'b1);
    chk("p_b2b_first", {16'd0, p}, 32'h000000F0);
    op(8'hA5, 8'h3C, 1'b1);
    chk("p_b2b_second", {16'd0, p}, 32'h000026AC);
    chk("b2b_spacing", done_t[t0+1] - done_t[t0], 32'd6);

    // Re-pulse start during CALC and DONE; operands change mid-operation.
    nd = n_done;
    a = 8'h12; b = 8'h34; start = 1'b1;
    exp_q.push_back(16'h03A8);
    @(negedge clk); start = 1'b0; a = 8'h01; b = 8'h01;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("ignore_in_done_busy", {31'd0, busy}, 32'd0);
    repeat (7) @(negedge clk);
    chk("single_done", n_done - nd, 32'd1);
    chk("repulse_p", {16'd0, p}, 32'h000003A8);
    last_p = 16'h03A8;

    // Reset during CALC step 2 abandons the operation.
    nd = n_done;
    a = 8'h77; b = 8'h99; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_p",    {16'd0, p},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_no_done", n_done - nd, 32'd0);
    last_p = 16'd0;
    op(8'h3C, 8'hA5, 1'b1);

    for (int i = 0; i < 6; i++) begin
      op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
    end

`ifdef SEQ_MUL8_OPCNT_EN
    rst_n = 1'b0;
    @(negedge clk);
    chk("opcnt_cleared", {24'd0, op_cnt}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 257; i++) begin
      op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    end
    chk("opcnt_wrap", {24'd0, op_cnt}, 32'd1);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
